// File: rtl/dma_ctrl.sv
// DMA job sequencer: read burst into the rotate input buffer, run the rotate core,
// then write the result burst back out, generating byte addresses for both buffers.
module dma_ctrl #(
    parameter logic [7:0] IN_BASE  = 8'h00,
    parameter logic [7:0] OUT_BASE = 8'h00
) (
    input  logic        I_DCTL_HCLK,
    input  logic        I_DCTL_RESET,
    input  logic        I_DCTL_GO,
    input  logic [31:0] I_DCTL_SRC_ADDR,
    input  logic [31:0] I_DCTL_DST_ADDR,
    input  logic [4:0]  I_DCTL_WORDS,
    input  logic        I_DCTL_BEAT,
    input  logic        I_DCTL_DMA_DONE,
    input  logic        I_DCTL_ROT_DONE,
    output logic        O_DCTL_DMA_START,
    output logic [31:0] O_DCTL_DMA_ADDR,
    output logic [4:0]  O_DCTL_DMA_COUNT,
    output logic [2:0]  O_DCTL_DMA_SIZE,
    output logic        O_DCTL_DMA_WRITE,
    output logic [7:0]  O_DCTL_PIXEL_IN_ADDR0,
    output logic [7:0]  O_DCTL_PIXEL_IN_ADDR1,
    output logic [7:0]  O_DCTL_PIXEL_IN_ADDR2,
    output logic [7:0]  O_DCTL_PIXEL_IN_ADDR3,
    output logic [7:0]  O_DCTL_PIXEL_OUT_ADDR0,
    output logic [7:0]  O_DCTL_PIXEL_OUT_ADDR1,
    output logic [7:0]  O_DCTL_PIXEL_OUT_ADDR2,
    output logic [7:0]  O_DCTL_PIXEL_OUT_ADDR3,
    output logic        O_DCTL_ROT_START,
    output logic        O_DCTL_BUSY,
    output logic        O_DCTL_DONE
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_ROT     = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_WAIT = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

    logic [2:0]  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [4:0]  words_q, words_d;
    logic [4:0]  idx_q, idx_d;

    logic        start_q, start_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  count_q, count_d;
    logic        write_q, write_d;
    logic        rot_start_q, rot_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  pin_q  [4];
    logic [7:0]  pin_d  [4];
    logic [7:0]  pout_q [4];
    logic [7:0]  pout_d [4];

    logic        in_wait_s;

    // Byte address of lane k of the word at the given beat index, wrapping at 256.
    function automatic logic [7:0] pix_addr(input logic [7:0] base,
                                            input logic [4:0] idx,
                                            input logic [1:0] lane);
        pix_addr = base + {1'b0, idx, 2'b00} + {6'b000000, lane};
    endfunction

    // Next-state decode of the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (I_DCTL_GO) begin
                    state_d = (I_DCTL_WORDS == 5'd0) ? ST_FIN : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = I_DCTL_DMA_DONE ? ST_ROT : ST_RD_WAIT;
            ST_ROT:     state_d = I_DCTL_ROT_DONE ? ST_WR_REQ : ST_ROT;
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: state_d = I_DCTL_DMA_DONE ? ST_FIN : ST_WR_WAIT;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign in_wait_s = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);

    // Job parameters are captured only when a job is accepted.
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        words_d = words_q;
        if ((state_q == ST_IDLE) && I_DCTL_GO) begin
            src_d   = I_DCTL_SRC_ADDR;
            dst_d   = I_DCTL_DST_ADDR;
            words_d = I_DCTL_WORDS;
        end else begin
            src_d   = src_q;
            dst_d   = dst_q;
            words_d = words_q;
        end
    end

    // Beat index: cleared when a request phase is entered, saturates at the word count.
    always_comb begin
        idx_d = idx_q;
        if ((state_d == ST_RD_REQ) || (state_d == ST_WR_REQ)) begin
            idx_d = 5'd0;
        end else if (in_wait_s && I_DCTL_BEAT && (idx_q < words_q)) begin
            idx_d = idx_q + 5'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // Output register inputs; pixel addresses follow the next index so they move
    // the cycle after each beat.
    always_comb begin
        start_d     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
        addr_d      = addr_q;
        count_d     = count_q;
        write_d     = write_q;
        rot_start_d = (state_q == ST_RD_WAIT) && I_DCTL_DMA_DONE;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_q == ST_FIN);
        if (state_q == ST_RD_REQ) begin
            addr_d  = src_q;
            count_d = words_q;
            write_d = 1'b0;
        end else if (state_q == ST_WR_REQ) begin
            addr_d  = dst_q;
            count_d = words_q;
            write_d = 1'b1;
        end else begin
            addr_d  = addr_q;
            count_d = count_q;
            write_d = write_q;
        end
        for (int k = 0; k < 4; k++) begin
            pin_d[k]  = pix_addr(IN_BASE, idx_d, 2'(k));
            pout_d[k] = pix_addr(OUT_BASE, idx_d, 2'(k));
        end
    end

    // State, job parameters and all registered outputs.
    always_ff @(posedge I_DCTL_HCLK or posedge I_DCTL_RESET) begin
        if (I_DCTL_RESET) begin
            state_q     <= ST_IDLE;
            src_q       <= 32'h0000_0000;
            dst_q       <= 32'h0000_0000;
            words_q     <= 5'd0;
            idx_q       <= 5'd0;
            start_q     <= 1'b0;
            addr_q      <= 32'h0000_0000;
            count_q     <= 5'd0;
            write_q     <= 1'b0;
            rot_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                pin_q[k]  <= pix_addr(IN_BASE, 5'd0, 2'(k));
                pout_q[k] <= pix_addr(OUT_BASE, 5'd0, 2'(k));
            end
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            write_q     <= write_d;
            rot_start_q <= rot_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int k = 0; k < 4; k++) begin
                pin_q[k]  <= pin_d[k];
                pout_q[k] <= pout_d[k];
            end
        end
    end

    assign O_DCTL_DMA_START       = start_q;
    assign O_DCTL_DMA_ADDR        = addr_q;
    assign O_DCTL_DMA_COUNT       = count_q;
    assign O_DCTL_DMA_SIZE        = DMA_SIZE_WORD;
    assign O_DCTL_DMA_WRITE       = write_q;
    assign O_DCTL_PIXEL_IN_ADDR0  = pin_q[0];
    assign O_DCTL_PIXEL_IN_ADDR1  = pin_q[1];
    assign O_DCTL_PIXEL_IN_ADDR2  = pin_q[2];
    assign O_DCTL_PIXEL_IN_ADDR3  = pin_q[3];
    assign O_DCTL_PIXEL_OUT_ADDR0 = pout_q[0];
    assign O_DCTL_PIXEL_OUT_ADDR1 = pout_q[1];
    assign O_DCTL_PIXEL_OUT_ADDR2 = pout_q[2];
    assign O_DCTL_PIXEL_OUT_ADDR3 = pout_q[3];
    assign O_DCTL_ROT_START       = rot_start_q;
    assign O_DCTL_BUSY            = busy_q;
    assign O_DCTL_DONE            = done_q;

endmodule
